// File: rtl/vector_mem_arbiter_pkg.sv
// Shared request/response types and sizing helpers for the vector memory arbiter.
package vector_mem_arbiter_pkg;

  localparam int unsigned CORE_ID_W   = 8;
  localparam int unsigned ACCESS_ID_W = 6;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 64;
  localparam int unsigned BE_W        = DATA_W / 8;

  typedef enum logic {
    READ_REQ  = 1'b0,
    WRITE_REQ = 1'b1
  } access_type_e;

  typedef struct packed {
    logic                   vld;
    logic [CORE_ID_W-1:0]   core_id;
    logic [ACCESS_ID_W-1:0] access_id;
    logic [ADDR_W-1:0]      addr;
    logic [BE_W-1:0]        byte_en;
    logic [DATA_W-1:0]      data;
    access_type_e           access_type;
  } request_t;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_cnt);
    return $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/vector_mem_arbiter_if.sv
// Bundle of requester, memory and status signals around the vector memory arbiter.
interface vector_mem_arbiter_if #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MAX_OUTSTANDING = 64
);
  import vector_mem_arbiter_pkg::*;

  localparam int unsigned CNT_W = cnt_width(MAX_OUTSTANDING);

  request_t [NUM_REQ-1:0]            req_in;
  logic     [NUM_REQ-1:0]            req_grant;
  request_t                          mem_req;
  logic                              mem_grant;
  request_t                          mem_rsp;
  request_t [NUM_REQ-1:0]            rsp_out;
  logic     [NUM_REQ-1:0][CNT_W-1:0] outstanding;
  logic                              route_err;

  // Requester/memory side (environment).
  modport master (
    output req_in, mem_grant, mem_rsp,
    input  req_grant, mem_req, rsp_out, outstanding, route_err
  );

  // Arbiter side.
  modport slave (
    input  req_in, mem_grant, mem_rsp,
    output req_grant, mem_req, rsp_out, outstanding, route_err
  );

endinterface

// File: rtl/vector_rr_picker.sv
// Round-robin picker: first set request at or above ptr, wrapping to index 0.
module vector_rr_picker
  import vector_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic               valid
);

  logic [NUM_REQ-1:0] req_hi;
  logic [NUM_REQ-1:0] req_src;
  logic               found;

  // Requests at or above the pointer win first; otherwise wrap to the lowest.
  always_comb begin
    req_hi = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_hi[i] = req[i] && (PTR_W'(i) >= ptr);
    end
    req_src = (|req_hi) ? req_hi : req;
  end

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_src[i] && !found) begin
        onehot[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/vector_mem_arbiter.sv
// Round-robin arbiter sharing one memory port among vector requesters, with
// per-requester outstanding tracking and core_id-based response routing.
module vector_mem_arbiter
  import vector_mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned BASE_CORE_ID    = 8,
  parameter int unsigned MAX_OUTSTANDING = 64
) (
  input logic                  clk,
  input logic                  reset,
  vector_mem_arbiter_if.slave  bus
);

  localparam int unsigned      PTR_W   = ptr_width(NUM_REQ);
  localparam int unsigned      CNT_W   = cnt_width(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [NUM_REQ-1:0]            eligible;
  logic [NUM_REQ-1:0]            pick_onehot;
  logic                          pick_valid;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            rsp_sel;
  logic [NUM_REQ-1:0]            underflow;
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_all;
  request_t [NUM_REQ-1:0]        rsp_all;

  logic                          slot_free;
  logic                          capture;
  logic [PTR_W-1:0]              rr_ptr_q;
  logic [PTR_W-1:0]              win_idx;
  logic [PTR_W-1:0]              next_ptr;
  request_t                      win_req;
  request_t                      mem_req_q;
  logic                          unmapped;
  logic                          route_err_q;

  vector_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req    (eligible),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .valid  (pick_valid)
  );

  assign slot_free = !mem_req_q.vld || bus.mem_grant;
  assign capture   = slot_free && pick_valid && !reset;
  assign grant     = capture ? pick_onehot : '0;

  always_comb begin
    win_idx = '0;
    win_req = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (pick_onehot[i]) begin
        win_idx = PTR_W'(i);
        win_req = bus.req_in[i];
      end
    end
  end

  assign next_ptr = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  // A stalled mem_req keeps every field frozen until memory accepts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_q <= '0;
      rr_ptr_q  <= '0;
    end else if (slot_free) begin
      if (pick_valid) begin
        mem_req_q     <= win_req;
        mem_req_q.vld <= 1'b1;
        rr_ptr_q      <= next_ptr;
      end else begin
        mem_req_q.vld <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    localparam logic [CORE_ID_W-1:0] MY_ID = CORE_ID_W'(BASE_CORE_ID + i);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             uflow;
    request_t         rsp_q;

    assign eligible[i] = bus.req_in[i].vld && (cnt_q < CNT_MAX);
    assign rsp_sel[i]  = bus.mem_rsp.vld && (bus.mem_rsp.core_id == MY_ID);

    // Grant and response in the same cycle cancel out.
    always_comb begin
      cnt_d = cnt_q;
      uflow = 1'b0;
      if (grant[i] && !rsp_sel[i]) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!grant[i] && rsp_sel[i]) begin
        if (cnt_q == '0) begin
          uflow = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        rsp_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        if (rsp_sel[i]) begin
          rsp_q <= bus.mem_rsp;
        end else begin
          rsp_q.vld <= 1'b0;
        end
      end
    end

    assign underflow[i] = uflow;
    assign cnt_all[i]   = cnt_q;
    assign rsp_all[i]   = rsp_q;
  end

  assign unmapped = bus.mem_rsp.vld && !(|rsp_sel);

  always_ff @(posedge clk) begin
    if (reset) begin
      route_err_q <= 1'b0;
    end else if (unmapped || (|underflow)) begin
      route_err_q <= 1'b1;
    end
  end

  assign bus.req_grant   = grant;
  assign bus.mem_req     = mem_req_q;
  assign bus.rsp_out     = rsp_all;
  assign bus.outstanding = cnt_all;
  assign bus.route_err   = route_err_q;

endmodule

// File: tb/tb_vector_mem_arbiter.sv
// Scoreboard bench for vector_mem_arbiter: directed stimulus, queue-based monitor.
module tb_vector_mem_arbiter;
  import vector_mem_arbiter_pkg::*;

  typedef struct packed {
    logic [1:0] idx;
    request_t   rsp;
  } exp_rsp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  vector_mem_arbiter_if #(.NUM_REQ(4), .MAX_OUTSTANDING(64)) bus_a ();
  vector_mem_arbiter_if #(.NUM_REQ(4), .MAX_OUTSTANDING(2))  bus_b ();

  vector_mem_arbiter #(
    .NUM_REQ         (4),
    .BASE_CORE_ID    (8),
    .MAX_OUTSTANDING (64)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  vector_mem_arbiter #(
    .NUM_REQ         (4),
    .BASE_CORE_ID    (8),
    .MAX_OUTSTANDING (2)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  request_t exp_mem_a[$];
  request_t exp_mem_b[$];
  exp_rsp_t exp_rsp_a[$];
  exp_rsp_t exp_rsp_b[$];
  int       n_checks = 0;
  int       n_fail   = 0;

  function automatic request_t mk(input int unsigned i, input int unsigned tag);
    request_t r;
    r.vld         = 1'b1;
    r.core_id     = CORE_ID_W'(8 + i);
    r.access_id   = ACCESS_ID_W'(tag);
    r.addr        = ADDR_W'(32'h1000_0000 + i * 256 + tag * 4);
    r.byte_en     = BE_W'(8'hFF ^ tag);
    r.data        = {32'hDA7A_0000 | 32'(i), 32'(tag)};
    r.access_type = tag[0] ? WRITE_REQ : READ_REQ;
    return r;
  endfunction

  function automatic request_t mk_rsp(input int unsigned core, input int unsigned tag);
    request_t r;
    r             = '0;
    r.vld         = 1'b1;
    r.core_id     = CORE_ID_W'(core);
    r.access_id   = ACCESS_ID_W'(tag);
    r.addr        = ADDR_W'(32'h2000_0000 + tag);
    r.data        = 64'hBEEF_0000_0000_0000 | 64'(tag);
    r.access_type = READ_REQ;
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got an output pulse, expected none", name);
  endtask

  task automatic check_cnt(input string name, input int c0, input int c1, input int c2,
                           input int c3);
    check({name, "_0"}, 128'(bus_a.outstanding[0]), 128'(c0));
    check({name, "_1"}, 128'(bus_a.outstanding[1]), 128'(c1));
    check({name, "_2"}, 128'(bus_a.outstanding[2]), 128'(c2));
    check({name, "_3"}, 128'(bus_a.outstanding[3]), 128'(c3));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // Monitor: every accepted mem_req and every rsp_out pulse consumes one expectation.
  always @(negedge clk) begin
    if (bus_a.mem_req.vld && bus_a.mem_grant) begin
      if (exp_mem_a.size() == 0) unexpected("mem_req_a");
      else check("mem_req_a", 128'(bus_a.mem_req), 128'(exp_mem_a.pop_front()));
    end
    if (bus_b.mem_req.vld && bus_b.mem_grant) begin
      if (exp_mem_b.size() == 0) unexpected("mem_req_b");
      else check("mem_req_b", 128'(bus_b.mem_req), 128'(exp_mem_b.pop_front()));
    end
    for (int i = 0; i < 4; i++) begin
      if (bus_a.rsp_out[i].vld) begin
        if (exp_rsp_a.size() == 0) unexpected("rsp_out_a");
        else check("rsp_out_a", 128'({2'(i), bus_a.rsp_out[i]}), 128'(exp_rsp_a.pop_front()));
      end
      if (bus_b.rsp_out[i].vld) begin
        if (exp_rsp_b.size() == 0) unexpected("rsp_out_b");
        else check("rsp_out_b", 128'({2'(i), bus_b.rsp_out[i]}), 128'(exp_rsp_b.pop_front()));
      end
    end
  end

  initial begin
    reset           = 1'b1;
    bus_a.req_in    = '0;
    bus_a.mem_grant = 1'b0;
    bus_a.mem_rsp   = '0;
    bus_b.req_in    = '0;
    bus_b.mem_grant = 1'b0;
    bus_b.mem_rsp   = '0;
    bus_a.req_in[0] = mk(0, 0);

    // Reset state
    samp();
    check("grant_during_reset", 128'(bus_a.req_grant), 128'(0));
    tick();
    tick();
    samp();
    check("mem_req_vld_reset", 128'(bus_a.mem_req.vld), 128'(0));
    check_cnt("outstanding_reset", 0, 0, 0, 0);
    check("route_err_reset", 128'(bus_a.route_err), 128'(0));
    tick();
    reset              = 1'b0;
    bus_a.req_in[0].vld = 1'b0;

    // All four requesters, memory always ready: strict rotation 0,1,2,3,0
    for (int i = 0; i < 4; i++) bus_a.req_in[i] = mk(i, 1);
    bus_a.mem_grant = 1'b1;
    for (int k = 0; k < 5; k++) exp_mem_a.push_back(mk(k % 4, 1));
    for (int k = 0; k < 5; k++) begin
      samp();
      check("rr_grant", 128'(bus_a.req_grant), 128'(1 << (k % 4)));
      tick();
    end
    for (int i = 0; i < 4; i++) bus_a.req_in[i].vld = 1'b0;
    samp();
    check_cnt("outstanding_after_rr", 2, 1, 1, 1);
    tick();

    // Memory stall: requester 2 granted once, request held for 5 cycles
    bus_a.mem_grant = 1'b0;
    bus_a.req_in[2] = mk(2, 2);
    exp_mem_a.push_back(mk(2, 2));
    samp();
    check("stall_first_grant", 128'(bus_a.req_grant), 128'(4'b0100));
    tick();
    bus_a.req_in[2].vld = 1'b0;
    bus_a.req_in[0]     = mk(0, 2);
    for (int k = 0; k < 5; k++) begin
      samp();
      check("stall_no_grant", 128'(bus_a.req_grant), 128'(0));
      check("stall_mem_req_held", 128'(bus_a.mem_req), 128'(mk(2, 2)));
      tick();
    end
    bus_a.mem_grant = 1'b1;
    exp_mem_a.push_back(mk(0, 2));
    samp();
    check("stall_release_grant", 128'(bus_a.req_grant), 128'(4'b0001));
    tick();
    bus_a.req_in[0].vld = 1'b0;
    samp();
    tick();
    samp();
    check("mem_req_idle", 128'(bus_a.mem_req.vld), 128'(0));
    check_cnt("outstanding_after_stall", 3, 1, 2, 1);
    tick();

    // Grant and response for requester 1 in the same cycle
    bus_a.req_in[1] = mk(1, 3);
    for (int k = 0; k < 3; k++) exp_mem_a.push_back(mk(1, 3));
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        bus_a.mem_rsp = mk_rsp(9, 3);
        exp_rsp_a.push_back({2'd1, mk_rsp(9, 3)});
      end
      samp();
      check("req1_grant", 128'(bus_a.req_grant), 128'(4'b0010));
      if (k == 2) check("outstanding1_before_overlap", 128'(bus_a.outstanding[1]), 128'(3));
      tick();
    end
    bus_a.req_in[1].vld = 1'b0;
    bus_a.mem_rsp       = '0;
    samp();
    check("outstanding1_overlap", 128'(bus_a.outstanding[1]), 128'(3));
    tick();

    // Unmapped core_id: dropped, sticky error
    bus_a.mem_rsp = mk_rsp(20, 4);
    tick();
    bus_a.mem_rsp = '0;
    samp();
    check("route_err_set", 128'(bus_a.route_err), 128'(1));
    tick();
    tick();
    samp();
    check("route_err_sticky", 128'(bus_a.route_err), 128'(1));
    tick();

    // Build outstanding[3]=5 with a held mem_req, then reset mid-transfer
    bus_a.req_in[3] = mk(3, 5);
    for (int k = 0; k < 4; k++) exp_mem_a.push_back(mk(3, 5));
    for (int k = 0; k < 4; k++) begin
      samp();
      check("req3_grant", 128'(bus_a.req_grant), 128'(4'b1000));
      tick();
    end
    bus_a.req_in[3].vld = 1'b0;
    bus_a.req_in[1]     = mk(1, 5);
    samp();
    check("req1_grant_pre_reset", 128'(bus_a.req_grant), 128'(4'b0010));
    tick();
    bus_a.mem_grant     = 1'b0;
    bus_a.req_in[1].vld = 1'b0;
    samp();
    check("outstanding3_five", 128'(bus_a.outstanding[3]), 128'(5));
    check("mem_req_held_pre_reset", 128'(bus_a.mem_req.vld), 128'(1));
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) bus_a.req_in[i] = mk(i, 6);
    samp();
    check("grant_in_reset_cycle", 128'(bus_a.req_grant), 128'(0));
    tick();
    reset = 1'b0;
    exp_mem_a.push_back(mk(0, 6));
    samp();
    check("mem_req_vld_post_reset", 128'(bus_a.mem_req.vld), 128'(0));
    check_cnt("outstanding_post_reset", 0, 0, 0, 0);
    check("route_err_cleared", 128'(bus_a.route_err), 128'(0));
    check("first_grant_post_reset", 128'(bus_a.req_grant), 128'(4'b0001));
    tick();
    for (int i = 0; i < 4; i++) bus_a.req_in[i].vld = 1'b0;
    bus_a.mem_grant = 1'b1;
    samp();
    tick();

    // Normal decrement, then decrement at zero
    bus_a.mem_rsp = mk_rsp(8, 7);
    exp_rsp_a.push_back({2'd0, mk_rsp(8, 7)});
    tick();
    bus_a.mem_rsp = '0;
    samp();
    check("outstanding0_dec", 128'(bus_a.outstanding[0]), 128'(0));
    check("route_err_after_dec", 128'(bus_a.route_err), 128'(0));
    tick();
    bus_a.mem_rsp = mk_rsp(9, 8);
    exp_rsp_a.push_back({2'd1, mk_rsp(9, 8)});
    tick();
    bus_a.mem_rsp = '0;
    samp();
    check("outstanding1_saturate", 128'(bus_a.outstanding[1]), 128'(0));
    check("route_err_underflow", 128'(bus_a.route_err), 128'(1));
    tick();

    // MAX_OUTSTANDING=2: two grants, blocked, response unblocks a third
    bus_b.mem_grant = 1'b1;
    bus_b.req_in[0] = mk(0, 9);
    for (int k = 0; k < 3; k++) exp_mem_b.push_back(mk(0, 9));
    samp();
    check("b_grant_1", 128'(bus_b.req_grant), 128'(4'b0001));
    tick();
    samp();
    check("b_grant_2", 128'(bus_b.req_grant), 128'(4'b0001));
    tick();
    samp();
    check("b_blocked", 128'(bus_b.req_grant), 128'(0));
    check("b_outstanding_cap", 128'(bus_b.outstanding[0]), 128'(2));
    tick();
    samp();
    check("b_still_blocked", 128'(bus_b.req_grant), 128'(0));
    tick();
    bus_b.mem_rsp = mk_rsp(8, 10);
    exp_rsp_b.push_back({2'd0, mk_rsp(8, 10)});
    samp();
    check("b_blocked_rsp_cycle", 128'(bus_b.req_grant), 128'(0));
    tick();
    bus_b.mem_rsp = '0;
    samp();
    check("b_grant_3", 128'(bus_b.req_grant), 128'(4'b0001));
    check("b_outstanding_after_rsp", 128'(bus_b.outstanding[0]), 128'(1));
    tick();
    bus_b.req_in[0].vld = 1'b0;
    samp();
    tick();
    tick();
    samp();

    check("exp_mem_a_drained", 128'(exp_mem_a.size()), 128'(0));
    check("exp_mem_b_drained", 128'(exp_mem_b.size()), 128'(0));
    check("exp_rsp_a_drained", 128'(exp_rsp_a.size()), 128'(0));
    check("exp_rsp_b_drained", 128'(exp_rsp_b.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_mem_arbiter.md
VECTOR_MEM_ARBITER -- requirements
Module: vector_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of vector load/store requesters sharing one memory port.
REQ-002 SHALL have parameter BASE_CORE_ID, default 8: requester i owns core_id BASE_CORE_ID+i.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 64: per-requester cap on granted-but-unanswered requests.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 req_in[NUM_REQ]  input  request_t  per-requester memory request; vld held until granted.
REQ-008 req_grant[NUM_REQ]  output  1 each  request accepted this cycle (combinational).
REQ-009 mem_req  output  request_t  registered request to memory.
REQ-010 mem_grant  input  1  memory accepted current mem_req.
REQ-011 mem_rsp  input  request_t  memory response, one per request, tagged with core_id.
REQ-012 rsp_out[NUM_REQ]  output  request_t  response routed to owning requester (registered).
REQ-013 outstanding[NUM_REQ]  output  $clog2(MAX_OUTSTANDING+1) each  live outstanding count.
REQ-014 route_err  output  1  sticky: response with unmapped core_id seen.

Function
REQ-015 Eligible(i) = req_in[i].vld AND outstanding[i] < MAX_OUTSTANDING.
REQ-016 Output slot free = !mem_req.vld OR mem_grant; capture SHALL occur only when free and an eligible requester exists.
REQ-017 Winner SHALL be the first eligible index searching upward from rr_ptr, wrapping NUM_REQ-1 -> 0.
REQ-018 On capture: mem_req <= req_in[winner] with vld=1; req_grant[winner]=1 same cycle; all other grants 0; rr_ptr <= winner+1 modulo NUM_REQ.
REQ-019 Slot free and no eligible requester: mem_req.vld <= 0; rr_ptr unchanged.
REQ-020 mem_req.vld high and mem_grant low: mem_req SHALL hold stable; no grants issued.
REQ-021 Request latency: req_in to mem_req.vld = 1 cycle; back-to-back captures every cycle while mem_grant stays high.
REQ-022 req_in fields SHALL pass unmodified (core_id, access_id, addr, byte_en, data, access_type).
REQ-023 outstanding[i] SHALL +1 on req_grant[i], -1 on rsp_out[i].vld being loaded; both same cycle -> unchanged.
REQ-024 Decrement at 0 SHALL saturate at 0 and set route_err; increment SHALL never exceed MAX_OUTSTANDING (guaranteed by REQ-015).
REQ-025 mem_rsp.vld with core_id in [BASE_CORE_ID, BASE_CORE_ID+NUM_REQ-1]: rsp_out[core_id-BASE_CORE_ID] <= mem_rsp next cycle; others' vld <= 0.
REQ-026 mem_rsp.vld with core_id outside range: response dropped, route_err <= 1 (sticky until reset).
REQ-027 rsp_out[*].vld SHALL be single-cycle pulses; no backpressure on responses.

Reset
REQ-028 On reset: mem_req <= 0, rsp_out[*] <= 0, outstanding[*] <= 0, rr_ptr <= 0, route_err <= 0; req_grant[*] SHALL be 0 during reset.
REQ-029 Reset mid-transfer SHALL discard the held mem_req and all counts; no grant in the reset cycle.

Structure
REQ-030 request_t, READ_REQ/WRITE_REQ and core-id width SHALL come from the shared vector package; NUM_REQ, BASE_CORE_ID, MAX_OUTSTANDING stay module parameters.
REQ-031 One sub-module vector_rr_picker (request vector + pointer -> one-hot winner, valid) SHALL implement REQ-017.
REQ-032 Per-requester counters and response demux SHALL be generate loops in the top module.

Verification
REQ-033 All 4 requesters vld, mem_grant=1 constant -> grants 0,1,2,3,0 in consecutive cycles, mem_req.core_id 8,9,10,11,8.
REQ-034 Requester 2 vld, mem_grant=0 for 5 cycles -> grant[2] once, mem_req stable 5 cycles, released cycle after mem_grant=1.
REQ-035 MAX_OUTSTANDING=2, requester 0 streaming, no responses -> exactly 2 grants, then blocked; one mem_rsp core_id=8 -> rsp_out[0].vld next cycle, third grant follows.
REQ-036 Grant to requester 1 and mem_rsp core_id=9 same cycle with outstanding[1]=3 -> outstanding[1] stays 3.
REQ-037 mem_rsp core_id=20 -> no rsp_out pulse, route_err=1 and held; reset -> route_err=0.
REQ-038 Reset asserted while mem_req.vld=1 and outstanding[3]=5 -> next cycle mem_req.vld=0, outstanding all 0, first post-reset grant to requester 0.
